// File: rtl/bank_cmd_arbiter_pkg.sv
// Shared types for the bank command arbiter.
//   bank_state_t : state encoding driven by every bank FSM
//   dram_cmd_t   : command encoding on the DRAM command bus
//   req_cmd      : command a bank is asking for while in a *_CHECK state
//   issue_cmd    : command a bank is putting on the bus while in an issue state
//   load_val     : timing counter reload value for a timing parameter
//   cnt_dec      : saturating-at-zero counter decrement
// Timing defaults live here so every user sees the same values.
package bank_cmd_arbiter_pkg;

  localparam int FSM_WIDTH = 4;
  localparam int CNT_W     = 5;

  // Timing defaults, in clock cycles.
  localparam int DEF_NUM_BANKS = 8;
  localparam int DEF_ADDR_BITS = 14;
  localparam int DEF_T_RCD     = 4;
  localparam int DEF_T_RP      = 4;
  localparam int DEF_T_RAS     = 10;
  localparam int DEF_T_RRD     = 2;
  localparam int DEF_T_CCD     = 2;
  localparam int DEF_T_WTR     = 6;

  typedef enum logic [FSM_WIDTH-1:0] {
    B_IDLE          = 4'd0,
    B_ACT_CHECK     = 4'd1,
    B_ACTIVE        = 4'd2,
    B_BANK_ACTIVE   = 4'd3,
    B_READ_CHECK    = 4'd4,
    B_READ          = 4'd5,
    B_WRITE_CHECK   = 4'd6,
    B_WRITE         = 4'd7,
    B_PRE_CHECK     = 4'd8,
    B_PRE           = 4'd9,
    B_REFRESH_CHECK = 4'd10,
    B_REFRESH       = 4'd11
  } bank_state_t;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } dram_cmd_t;

  function automatic dram_cmd_t req_cmd(bank_state_t s);
    case (s)
      B_ACT_CHECK:   return CMD_ACT;
      B_READ_CHECK:  return CMD_RD;
      B_WRITE_CHECK: return CMD_WR;
      B_PRE_CHECK:   return CMD_PRE;
      default:       return CMD_NOP;
    endcase
  endfunction

  function automatic dram_cmd_t issue_cmd(bank_state_t s);
    case (s)
      B_ACTIVE:  return CMD_ACT;
      B_READ:    return CMD_RD;
      B_WRITE:   return CMD_WR;
      B_PRE:     return CMD_PRE;
      B_REFRESH: return CMD_REF;
      default:   return CMD_NOP;
    endcase
  endfunction

  // A parameter of 0 is treated like 1: no cycles of blocking.
  function automatic logic [CNT_W-1:0] load_val(int t);
    if (t <= 1) return '0;
    return CNT_W'(t - 1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_dec(logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

endpackage

// File: rtl/bank_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i   : request vector, one bit per requester
//   ptr_i   : index that has highest priority this cycle
//   grant_o : one-hot grant (all zero when nothing is requested)
//   valid_o : a grant was made
module rr_arbiter #(
  parameter int N = 8,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic          valid_o
);

  logic [PW-1:0] sel;

  // Walk the requesters starting at ptr_i, wrapping around; first hit wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    sel     = '0;
    for (int i = 0; i < N; i++) begin
      sel = PW'((int'(ptr_i) + i) % N);
      if (!valid_o && req_i[sel]) begin
        grant_o[sel] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_cmd_arbiter.sv
// Bank command arbiter: picks at most one bank command per cycle, enforces
// DRAM inter-command timing and registers one command onto the DRAM bus.
//   clk, rst   : clock, asynchronous active-high reset
//   ba_state   : packed bank_state_t of every bank FSM
//   ba_issue   : bank is in an issue state this cycle
//   ba_addr    : packed row/column address of every bank
//   stall      : per-bank stall, 0 only for the bank granted this cycle
//   dram_cmd   : registered dram_cmd_t
//   dram_ba    : registered bank of dram_cmd
//   dram_addr  : registered address of dram_cmd
//
// Handshake: a bank sitting in a *_CHECK state is a request (valid). stall
// low for that bank in the same cycle is the acceptance (ready); the bank
// then moves to its issue state in the next cycle and the arbiter registers
// that issue onto the bus one cycle later. A bank must hold its *_CHECK
// state while stall is high.
module bank_cmd_arbiter
  import bank_cmd_arbiter_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int T_RCD     = DEF_T_RCD,
  parameter int T_RP      = DEF_T_RP,
  parameter int T_RAS     = DEF_T_RAS,
  parameter int T_RRD     = DEF_T_RRD,
  parameter int T_CCD     = DEF_T_CCD,
  parameter int T_WTR     = DEF_T_WTR
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_BANKS*FSM_WIDTH-1:0] ba_state,
  input  logic [NUM_BANKS-1:0]           ba_issue,
  input  logic [NUM_BANKS*ADDR_BITS-1:0] ba_addr,
  output logic [NUM_BANKS-1:0]           stall,
  output logic [2:0]                     dram_cmd,
  output logic [2:0]                     dram_ba,
  output logic [ADDR_BITS-1:0]           dram_addr
);

  localparam int IDXW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [CNT_W-1:0] L_RCD = load_val(T_RCD);
  localparam logic [CNT_W-1:0] L_RP  = load_val(T_RP);
  localparam logic [CNT_W-1:0] L_RAS = load_val(T_RAS);
  localparam logic [CNT_W-1:0] L_RRD = load_val(T_RRD);
  localparam logic [CNT_W-1:0] L_CCD = load_val(T_CCD);
  localparam logic [CNT_W-1:0] L_WTR = load_val(T_WTR);

  bank_state_t st     [NUM_BANKS];
  bank_state_t prev_q [NUM_BANKS];

  logic [CNT_W-1:0] rcd_q [NUM_BANKS];
  logic [CNT_W-1:0] rp_q  [NUM_BANKS];
  logic [CNT_W-1:0] ras_q [NUM_BANKS];
  logic [CNT_W-1:0] rrd_q, ccd_q, wtr_q;

  logic [NUM_BANKS-1:0] ref_pending_q, ref_pending_d;
  logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;

  logic [NUM_BANKS-1:0] elig, req_v, grant, new_ref, pend_all, is_ref, ref_chk;
  logic [NUM_BANKS-1:0] issue_mask, ref_clr;
  logic                 grant_vld, suppress, ref_hit, iss_hit;
  logic [IDXW-1:0]      g_idx, ref_idx, iss_idx;
  dram_cmd_t            g_cmd, cmd_d;
  logic [2:0]           ba_d;
  logic [ADDR_BITS-1:0] addr_d;

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++)
      st[b] = bank_state_t'(ba_state[b*FSM_WIDTH +: FSM_WIDTH]);
  end

  // A bank is eligible when it requests and every timer guarding its command is idle.
  always_comb begin
    elig    = '0;
    is_ref  = '0;
    ref_chk = '0;
    new_ref = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      case (req_cmd(st[b]))
        CMD_ACT: elig[b] = (rp_q[b] == '0) && (rrd_q == '0);
        CMD_RD:  elig[b] = (rcd_q[b] == '0) && (ccd_q == '0) && (wtr_q == '0);
        CMD_WR:  elig[b] = (rcd_q[b] == '0) && (ccd_q == '0);
        CMD_PRE: elig[b] = (ras_q[b] == '0);
        default: elig[b] = 1'b0;
      endcase
      is_ref[b]  = (st[b] == B_REFRESH);
      ref_chk[b] = (st[b] == B_REFRESH_CHECK);
      // Only the first cycle of a refresh dwell produces a REF.
      new_ref[b] = is_ref[b] && (prev_q[b] != B_REFRESH);
    end
  end

  // Refreshes just entering the queue also block grants, so a granted
  // command can never reach the bus while REFs are still draining.
  assign pend_all = ref_pending_q | new_ref;
  assign suppress = (|ref_chk) || (|pend_all);
  assign req_v    = suppress ? '0 : elig;

  rr_arbiter #(.N(NUM_BANKS)) u_rr (
    .req_i   (req_v),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .valid_o (grant_vld)
  );

  assign stall = rst ? '1 : ~grant;

  always_comb begin
    g_idx = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (grant[b]) g_idx = IDXW'(b);
    g_cmd    = grant_vld ? req_cmd(st[g_idx]) : CMD_NOP;
    rr_ptr_d = grant_vld ? IDXW'((int'(g_idx) + 1) % NUM_BANKS) : rr_ptr_q;
  end

  // Lowest-index pending REF, and lowest-index non-refresh issuer.
  assign issue_mask = ba_issue & ~is_ref;

  always_comb begin
    ref_idx = '0;
    ref_hit = 1'b0;
    iss_idx = '0;
    iss_hit = 1'b0;
    ref_clr = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!ref_hit && pend_all[b]) begin
        ref_idx    = IDXW'(b);
        ref_hit    = 1'b1;
        ref_clr[b] = 1'b1;
      end
      if (!iss_hit && issue_mask[b]) begin
        iss_idx = IDXW'(b);
        iss_hit = 1'b1;
      end
    end
    ref_pending_d = pend_all & ~ref_clr;
  end

  always_comb begin
    cmd_d  = CMD_NOP;
    ba_d   = '0;
    addr_d = '0;
    if (ref_hit) begin
      cmd_d = CMD_REF;
      ba_d  = 3'(ref_idx);
    end else if (iss_hit && issue_cmd(st[iss_idx]) != CMD_NOP) begin
      cmd_d  = issue_cmd(st[iss_idx]);
      ba_d   = 3'(iss_idx);
      addr_d = ba_addr[int'(iss_idx)*ADDR_BITS +: ADDR_BITS];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        rcd_q[b]  <= '0;
        rp_q[b]   <= '0;
        ras_q[b]  <= '0;
        prev_q[b] <= B_IDLE;
      end
      rrd_q         <= '0;
      ccd_q         <= '0;
      wtr_q         <= '0;
      ref_pending_q <= '0;
      rr_ptr_q      <= '0;
      dram_cmd      <= CMD_NOP;
      dram_ba       <= '0;
      dram_addr     <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        rcd_q[b]  <= (grant[b] && g_cmd == CMD_ACT) ? L_RCD : cnt_dec(rcd_q[b]);
        ras_q[b]  <= (grant[b] && g_cmd == CMD_ACT) ? L_RAS : cnt_dec(ras_q[b]);
        rp_q[b]   <= (grant[b] && g_cmd == CMD_PRE) ? L_RP  : cnt_dec(rp_q[b]);
        prev_q[b] <= st[b];
      end
      rrd_q <= (g_cmd == CMD_ACT) ? L_RRD : cnt_dec(rrd_q);
      ccd_q <= (g_cmd == CMD_RD || g_cmd == CMD_WR) ? L_CCD : cnt_dec(ccd_q);
      wtr_q <= (g_cmd == CMD_WR) ? L_WTR : cnt_dec(wtr_q);
      ref_pending_q <= ref_pending_d;
      rr_ptr_q      <= rr_ptr_d;
      dram_cmd      <= cmd_d;
      dram_ba       <= ba_d;
      dram_addr     <= addr_d;
    end
  end

  // Two banks issuing in one cycle would collide on the bus; lowest index wins.
  a_one_issue: assert property (@(posedge clk) disable iff (rst) $onehot0(issue_mask));

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
module tb_bank_cmd_arbiter;
  import bank_cmd_arbiter_pkg::*;

  localparam int NB = 8;
  localparam int AB = 14;
  localparam int T_RCD = 4, T_RP = 4, T_RAS = 10, T_RRD = 2, T_CCD = 2, T_WTR = 6;
  localparam int FAR = -1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NB*FSM_WIDTH-1:0] ba_state;
  logic [NB-1:0]           ba_issue;
  logic [NB*AB-1:0]        ba_addr;
  logic [NB-1:0]           stall;
  logic [2:0]              dram_cmd, dram_ba;
  logic [AB-1:0]           dram_addr;

  bank_cmd_arbiter #(
    .NUM_BANKS(NB), .ADDR_BITS(AB), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS),
    .T_RRD(T_RRD), .T_CCD(T_CCD), .T_WTR(T_WTR)
  ) dut (
    .clk(clk), .rst(rst), .ba_state(ba_state), .ba_issue(ba_issue), .ba_addr(ba_addr),
    .stall(stall), .dram_cmd(dram_cmd), .dram_ba(dram_ba), .dram_addr(dram_addr)
  );

  // ---------------- bench state ----------------
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // bank FSM stand-ins
  bank_state_t   bst   [NB];
  int            dwell [NB];
  logic [AB-1:0] baddr [NB];
  bit drain = 0;
  bit force_ref = 0;

  // reference model: cycle stamps of the last relevant command
  int last_act [NB];
  int last_pre [NB];
  int last_act_any, last_rw_any, last_wr_any;
  int rr_ptr, g_prev;
  bit pend [NB];
  logic [2:0] last_gcmd;

  // expected bus entries: {due_cycle[31:0], cmd[2:0], ba[2:0], addr[13:0]}
  logic [51:0] exp_q[$];

  function automatic int tp(int t);
    return (t < 1) ? 1 : t;
  endfunction

  function automatic bit eligible(int b);
    case (bst[b])
      B_ACT_CHECK:   return (cyc - last_pre[b] >= tp(T_RP)) && (cyc - last_act_any >= tp(T_RRD));
      B_READ_CHECK:  return (cyc - last_act[b] >= tp(T_RCD)) && (cyc - last_rw_any >= tp(T_CCD)) &&
                            (cyc - last_wr_any >= tp(T_WTR));
      B_WRITE_CHECK: return (cyc - last_act[b] >= tp(T_RCD)) && (cyc - last_rw_any >= tp(T_CCD));
      B_PRE_CHECK:   return (cyc - last_act[b] >= tp(T_RAS));
      default:       return 1'b0;
    endcase
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int b = 0; b < NB; b++) begin
      ba_state[b*FSM_WIDTH +: FSM_WIDTH] = bst[b];
      ba_issue[b] = (bst[b] == B_ACTIVE || bst[b] == B_READ || bst[b] == B_WRITE ||
                     bst[b] == B_PRE || bst[b] == B_REFRESH);
      ba_addr[b*AB +: AB] = baddr[b];
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      bst[b] = B_IDLE;
      dwell[b] = 0;
      baddr[b] = '0;
      last_act[b] = FAR;
      last_pre[b] = FAR;
      pend[b] = 1'b0;
    end
    last_act_any = FAR;
    last_rw_any = FAR;
    last_wr_any = FAR;
    rr_ptr = 0;
    g_prev = -1;
    last_gcmd = CMD_NOP;
    exp_q.delete();
  endtask

  // Async reset: outputs must clear immediately, before any clock edge.
  task automatic apply_reset(int n);
    rst = 1'b1;
    #1;
    check("rst_stall", stall, {NB{1'b1}});
    check("rst_cmd", dram_cmd, CMD_NOP);
    check("rst_ba", dram_ba, 3'd0);
    check("rst_addr", dram_addr, '0);
    model_reset();
    drive_inputs();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- driver: one cycle of stimulus + model ----------------
  task automatic run_cycle();
    int g;
    int b;
    bit sup, found;
    bit newref [NB];
    logic [NB-1:0] exp_stall;
    logic [2:0] ecmd, eba;
    logic [AB-1:0] eaddr;
    int r;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NB; k++) begin
      newref[k] = 1'b0;
      baddr[k] = AB'($urandom_range(0, (1 << AB) - 1));
      case (bst[k])
        B_IDLE: begin
          r = $urandom_range(0, 15);
          if (force_ref) bst[k] = B_REFRESH_CHECK;
          else if (!drain && r < 4) bst[k] = B_ACT_CHECK;
          else if (!drain && r == 4) bst[k] = B_REFRESH_CHECK;
        end
        B_ACT_CHECK:   if (g_prev == k) bst[k] = B_ACTIVE;
        B_READ_CHECK:  if (g_prev == k) bst[k] = B_READ;
        B_WRITE_CHECK: if (g_prev == k) bst[k] = B_WRITE;
        B_PRE_CHECK:   if (g_prev == k) bst[k] = B_PRE;
        B_ACTIVE, B_READ, B_WRITE: bst[k] = B_BANK_ACTIVE;
        B_PRE: bst[k] = B_IDLE;
        B_BANK_ACTIVE: begin
          r = $urandom_range(0, 9);
          if (drain || r == 5) bst[k] = B_PRE_CHECK;
          else if (r < 3) bst[k] = B_READ_CHECK;
          else if (r < 5) bst[k] = B_WRITE_CHECK;
        end
        B_REFRESH_CHECK: begin
          bst[k] = B_REFRESH;
          dwell[k] = 3;
          newref[k] = 1'b1;
        end
        B_REFRESH: begin
          dwell[k]--;
          if (dwell[k] == 0) bst[k] = B_IDLE;
        end
        default: bst[k] = B_IDLE;
      endcase
    end
    drive_inputs();

    // grant: nothing while a refresh is being checked or REFs are queued
    sup = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (newref[k]) pend[k] = 1'b1;
      if (bst[k] == B_REFRESH_CHECK || pend[k]) sup = 1'b1;
    end
    g = -1;
    if (!sup)
      for (int i = 0; i < NB; i++) begin
        b = (rr_ptr + i) % NB;
        if (g < 0 && eligible(b)) g = b;
      end
    last_gcmd = CMD_NOP;
    if (g >= 0) begin
      case (bst[g])
        B_ACT_CHECK:   begin last_act[g] = cyc; last_act_any = cyc; last_gcmd = CMD_ACT; end
        B_PRE_CHECK:   begin last_pre[g] = cyc; last_gcmd = CMD_PRE; end
        B_READ_CHECK:  begin last_rw_any = cyc; last_gcmd = CMD_RD; end
        B_WRITE_CHECK: begin last_rw_any = cyc; last_wr_any = cyc; last_gcmd = CMD_WR; end
        default: ;
      endcase
      rr_ptr = (g + 1) % NB;
    end
    exp_stall = '1;
    if (g >= 0) exp_stall[g] = 1'b0;

    // bus: queued REFs first (lowest bank), otherwise the issuing bank
    ecmd = CMD_NOP;
    eba = 3'd0;
    eaddr = '0;
    found = 1'b0;
    for (int k = 0; k < NB; k++)
      if (!found && pend[k]) begin
        found = 1'b1;
        pend[k] = 1'b0;
        ecmd = CMD_REF;
        eba = 3'(k);
      end
    for (int k = 0; k < NB; k++)
      if (!found && (bst[k] == B_ACTIVE || bst[k] == B_READ || bst[k] == B_WRITE || bst[k] == B_PRE)) begin
        found = 1'b1;
        eba = 3'(k);
        eaddr = baddr[k];
        case (bst[k])
          B_ACTIVE: ecmd = CMD_ACT;
          B_READ:   ecmd = CMD_RD;
          B_WRITE:  ecmd = CMD_WR;
          default:  ecmd = CMD_PRE;
        endcase
      end
    exp_q.push_back({32'(cyc + 1), ecmd, eba, eaddr});

    @(negedge clk);
    check("stall", stall, exp_stall);
    g_prev = g;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [51:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (exp_q.size() > 0) begin
          e = exp_q[0];
          if (int'(e[51:20]) > cyc) break;
          void'(exp_q.pop_front());
          check("dram_cmd", dram_cmd, e[19:17]);
          check("dram_ba", dram_ba, e[16:14]);
          check("dram_addr", dram_addr, e[13:0]);
        end
      end
    end
  end

  function automatic bit all_idle();
    for (int k = 0; k < NB; k++)
      if (bst[k] != B_IDLE) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    model_reset();
    drive_inputs();
    #2;
    apply_reset(3);

    repeat (1500) run_cycle();

    // all banks refresh together; REFs drain one per cycle, grants wait
    drain = 1'b1;
    n = 0;
    while (!all_idle() && n < 300) begin
      run_cycle();
      n++;
    end
    if (!all_idle()) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: banks not idle after %0d cycles, required idle", n);
    end
    force_ref = 1'b1;
    run_cycle();
    force_ref = 1'b0;
    drain = 1'b0;
    repeat (40) run_cycle();

    // reset in the middle of an ACT grant
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (last_gcmd != CMD_ACT && n < 500);
    if (last_gcmd != CMD_ACT) begin
      vectors++;
      miscompares++;
      $display("FAIL act_wait_timeout: no ACT grant in %0d cycles, required one", n);
    end
    apply_reset(3);

    repeat (1500) run_cycle();
    drain = 1'b1;
    repeat (60) run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bank_cmd_arbiter.md
# bank_cmd_arbiter

Arbitrates the per-bank command requests of all bank FSMs in the command scheduler and drives one DRAM command per cycle onto the device command bus. It observes each bank FSM's state, issue flag and address. It enforces inter-command timing with per-bank and global counters and returns a per-bank `stall` that releases exactly one bank from its `*_CHECK` state per cycle. It sits directly downstream of the bank FSM array and upstream of the PHY command/address register.

## Interface
- NUM_BANKS, 8, number of bank FSMs served
- ADDR_BITS, 14, row/column address width
- T_RCD, 4, min cycles ACT→RD/WR, same bank
- T_RP, 4, min cycles PRE→ACT, same bank
- T_RAS, 10, min cycles ACT→PRE, same bank
- T_RRD, 2, min cycles ACT→ACT, any bank
- T_CCD, 2, min cycles RD/WR→RD/WR, any bank
- T_WTR, 6, min cycles WR→RD, any bank

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- ba_state  in  NUM_BANKS×FSM_WIDTH2  bank_state_t of each bank FSM
- ba_issue  in  NUM_BANKS  bank is in an issue state
- ba_addr  in  NUM_BANKS×ADDR_BITS  row/column address of each bank
- stall  out  NUM_BANKS  per-bank stall; 0 only for the granted bank
- dram_cmd  out  3  dram_cmd_t: NOP/ACT/RD/WR/PRE/REF, registered
- dram_ba  out  3  bank of dram_cmd, registered
- dram_addr  out  ADDR_BITS  address of dram_cmd, registered

## Operation
- Request map:
  - B_ACT_CHECK→ACT
  - B_READ_CHECK→RD
  - B_WRITE_CHECK→WR
  - B_PRE_CHECK→PRE
- Issue map:
  - B_ACTIVE→ACT
  - B_READ→RD
  - B_WRITE→WR
  - B_PRE→PRE
  - B_REFRESH→REF
- Eligibility: the bank is requesting and every counter that applies to its command is 0.
- Grant: at most one bank per cycle. Selection is round-robin among eligible banks, starting at rr_ptr. On a grant, rr_ptr ← grantee+1 mod NUM_BANKS; otherwise rr_ptr holds.
- `stall[b]` is combinational: 0 iff b is granted this cycle. It is all-ones while rst is asserted.
- Counters:
  - Loaded with T−1 in the grant cycle and decremented each cycle to 0.
  - Per-bank: rcd (on ACT), rp (on PRE), ras (on ACT).
  - Global: rrd (on ACT), ccd (on RD/WR), wtr (on WR).
  - A zero parameter behaves as 1.
  - Counter width is 5 bits; parameter values above 31 are illegal.
- Bus output: each cycle, dram_cmd/dram_ba/dram_addr register the issue-map command of the bank with ba_issue set, with dram_addr taken from ba_addr. If no bank has ba_issue set, the registered command is NOP with address 0.
- REF handling:
  - Only the first cycle of a bank's B_REFRESH dwell counts as a REF issue; this is detected against the registered previous state.
  - Each such bank sets a bit in a ref_pending mask.
  - One REF is emitted per cycle, lowest index first, and its bit is cleared.
- Grant suppression: no grant is made while any bank is in B_REFRESH_CHECK or ref_pending ≠ 0. This prevents bus collisions.

## Timing
- Grant in cycle N:
  - The bank is in its issue state in N+1.
  - The command is on the DRAM bus in N+2.
- A dependent grant is allowed no earlier than N+T, so the spacing on the bus equals T.
- Back-to-back grants on consecutive cycles are legal when no constraint applies.
- Reset values:
  - stall all 1.
  - dram_cmd NOP, dram_ba 0, dram_addr 0.
  - All counters 0, rr_ptr 0, ref_pending 0.
- Reset asserted mid-operation clears all of the above immediately. Commands in flight are dropped.
- Two ba_issue bits set in the same cycle is a protocol error, flagged by an assertion. In that case the lowest index wins.

## Structure
- dram_cmd_t and the request/issue mapping functions go in the usertype package, next to bank_state_t.
- Timing defaults go in define.sv.
- One sub-module: rr_arbiter. Inputs: NUM_BANKS request vector and pointer. Outputs: one-hot grant and a valid flag. It is combinational.
- Counters, REF queue and output register live in the top level.

## Test plan
- Bank 2: ACT_CHECK at cycle 0, T_RCD=4, READ_CHECK from cycle 2 → ACT on bus at cycle 2, RD granted at cycle 4, RD on bus at cycle 6, stall[2]=1 at cycles 2–3.
- Banks 0 and 1 both in ACT_CHECK at cycle 0, rr_ptr=0, T_RRD=2 → bank 0 granted at cycle 0, bank 1 at cycle 2; rr_ptr=2 afterwards.
- WR on bank 0 granted at cycle 0, RD request on bank 3 from cycle 1, T_WTR=6 → RD granted at cycle 6, not at cycle 2.
- ACT on bank 5 granted at cycle 0, PRE_CHECK at cycle 3, T_RAS=10 → PRE granted at cycle 10; same-bank ACT afterwards needs T_RP=4 → granted at cycle 14.
- All 8 banks enter B_REFRESH in the same cycle → REF for banks 0..7 on 8 consecutive cycles; a pending ACT_CHECK is not granted until ref_pending=0.
- rst asserted while an ACT is granted → outputs NOP/0 and stall all-ones immediately; after release, the first grant uses rr_ptr=0 and all counters are 0.
